// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word fetches,
// and feeds the decode pipe register through a 1-entry skid buffer.
module fetch_stage #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           INSN_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INSN_WIDTH-1:0] imem_rsp_data,
  input  logic                  dec_stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  dec_valid,
  output logic [ADDR_WIDTH-1:0] dec_pc,
  output logic [INSN_WIDTH-1:0] dec_instr
);

  typedef enum logic [1:0] {
    S_RUN,
    S_WAIT,
    S_DRAIN
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [ADDR_WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic [INSN_WIDTH-1:0] skid_instr_q, skid_instr_d;
  logic                  dec_valid_q, dec_valid_d;
  logic [ADDR_WIDTH-1:0] dec_pc_q, dec_pc_d;
  logic [INSN_WIDTH-1:0] dec_instr_q, dec_instr_d;

  logic                  req_valid;
  logic                  accept;
  logic                  slot_free;
  logic                  rsp_in_wait;
  logic [ADDR_WIDTH-1:0] redirect_tgt;

  assign redirect_tgt = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign slot_free    = !dec_valid_q || !dec_stall;
  assign rsp_in_wait  = (state_q == S_WAIT) && imem_rsp_valid;

  // Request is only offered from RUN with an empty skid; gated by reset so it
  // reads 0 while rst is held low.
  always_comb begin
    req_valid = 1'b0;
    if (state_q == S_RUN && !skid_valid_q) begin
      req_valid = 1'b1;
    end
  end

  assign imem_req_valid = req_valid & rst;
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid & imem_req_ready;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a redirect sends an in-flight request to DRAIN.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RUN: begin
        if (accept) begin
          state_d = redirect_valid ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_d = S_RUN;
        end else if (redirect_valid) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (imem_rsp_valid) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // PC, skid buffer and decode register next values.
  always_comb begin
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    dec_valid_d  = dec_valid_q;
    dec_pc_d     = dec_pc_q;
    dec_instr_d  = dec_instr_q;

    if (accept) begin
      req_pc_d = pc_q;
      pc_d     = pc_q + ADDR_WIDTH'(4);
    end

    if (redirect_valid) begin
      pc_d         = redirect_tgt;
      skid_valid_d = 1'b0;
      dec_valid_d  = 1'b0;
    end else if (slot_free) begin
      if (skid_valid_q) begin
        dec_valid_d  = 1'b1;
        dec_pc_d     = skid_pc_q;
        dec_instr_d  = skid_instr_q;
        skid_valid_d = 1'b0;
      end else if (rsp_in_wait) begin
        dec_valid_d = 1'b1;
        dec_pc_d    = req_pc_q;
        dec_instr_d = imem_rsp_data;
      end else begin
        dec_valid_d = 1'b0;
      end
    end else if (rsp_in_wait) begin
      // Skid is always empty here: no request is issued while it holds data.
      skid_valid_d = 1'b1;
      skid_pc_d    = req_pc_q;
      skid_instr_d = imem_rsp_data;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
      dec_valid_q  <= 1'b0;
      dec_pc_q     <= '0;
      dec_instr_q  <= '0;
    end else begin
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      dec_valid_q  <= dec_valid_d;
      dec_pc_q     <= dec_pc_d;
      dec_instr_q  <= dec_instr_d;
    end
  end

  assign dec_valid = dec_valid_q;
  assign dec_pc    = dec_pc_q;
  assign dec_instr = dec_instr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: random memory latency, stalls, back-pressure and
// redirects checked against a program-order model of fetch and decode.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;

  fetch_stage #(
    .ADDR_WIDTH(32),
    .INSN_WIDTH(32),
    .RESET_PC  (RST_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .dec_stall     (dec_stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .dec_valid     (dec_valid),
    .dec_pc        (dec_pc),
    .dec_instr     (dec_instr)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_A5A5;
  endfunction

  // Reference model: next address expected on the request bus, next PC
  // expected to be consumed by decode, and a single-slot memory.
  logic [31:0] exp_req, exp_dec;
  logic        mem_busy;
  int unsigned mem_cnt;
  logic [31:0] mem_addr;
  logic        pv_valid, pv_stall, pv_redir, pv_reqv, pv_ready;
  logic [31:0] pv_pc, pv_instr, pv_addr;
  int          cyc, first_acc, first_dv;
  int unsigned consumed, n_acc;
  int unsigned p_stall, p_redirect, p_notready, kmax;

  task automatic model_reset();
    exp_req   = RST_PC;
    exp_dec   = RST_PC;
    mem_busy  = 1'b0;
    mem_cnt   = 0;
    pv_valid  = 1'b0;
    pv_stall  = 1'b0;
    pv_redir  = 1'b0;
    pv_reqv   = 1'b0;
    pv_ready  = 1'b0;
    cyc       = 0;
    first_acc = -1;
    first_dv  = -1;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, "_dec_valid"}, 32'(dec_valid), 32'd0);
    chk({tag, "_dec_pc"}, dec_pc, 32'd0);
    chk({tag, "_dec_instr"}, dec_instr, 32'd0);
  endtask

  task automatic quiet_inputs();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    dec_stall      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
  endtask

  // One clock cycle; entered and left at a falling edge.
  task automatic cycle();
    logic busy0, rsp;
    busy0 = mem_busy;
    rsp   = 1'b0;
    if (mem_busy) begin
      if (mem_cnt == 1) begin
        rsp      = 1'b1;
        mem_busy = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(mem_addr) : $urandom;
    imem_req_ready = ($urandom_range(99) >= p_notready);
    dec_stall      = ($urandom_range(99) < p_stall);
    redirect_valid = ($urandom_range(99) < p_redirect);
    redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                              : $urandom;
    #1;
    if (pv_valid && pv_stall && !pv_redir) begin
      chk("stall_hold_valid", 32'(dec_valid), 32'd1);
      chk("stall_hold_pc", dec_pc, pv_pc);
      chk("stall_hold_instr", dec_instr, pv_instr);
    end
    if (pv_redir) chk("redirect_flush", 32'(dec_valid), 32'd0);
    if (pv_reqv && !pv_ready && !pv_redir) begin
      chk("req_hold_valid", 32'(imem_req_valid), 32'd1);
      chk("req_hold_addr", imem_req_addr, pv_addr);
    end
    if (dec_valid && first_dv < 0) first_dv = cyc;
    if (dec_valid && !dec_stall && !redirect_valid) begin
      chk("dec_pc", dec_pc, exp_dec);
      chk("dec_instr", dec_instr, mem_word(exp_dec));
      exp_dec = exp_dec + 32'd4;
      consumed++;
    end
    if (imem_req_valid && imem_req_ready) begin
      chk("one_outstanding", 32'(busy0), 32'd0);
      chk("req_addr", imem_req_addr, exp_req);
      if (first_acc < 0) first_acc = cyc;
      exp_req  = exp_req + 32'd4;
      mem_busy = 1'b1;
      mem_cnt  = $urandom_range(kmax, 1);
      mem_addr = imem_req_addr;
      n_acc++;
    end
    if (redirect_valid) begin
      exp_req = {redirect_pc[31:2], 2'b00};
      exp_dec = {redirect_pc[31:2], 2'b00};
    end
    pv_valid = dec_valid;
    pv_stall = dec_stall;
    pv_redir = redirect_valid;
    pv_pc    = dec_pc;
    pv_instr = dec_instr;
    pv_reqv  = imem_req_valid;
    pv_ready = imem_req_ready;
    pv_addr  = imem_req_addr;
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_knobs(input int unsigned s, input int unsigned r,
                           input int unsigned nr, input int unsigned k);
    p_stall    = s;
    p_redirect = r;
    p_notready = nr;
    kmax       = k;
  endtask

  initial begin
    int unsigned c0, a0;
    bit          found;
    consumed = 0;
    n_acc    = 0;
    rst      = 1'b0;
    quiet_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    #1 reset_checks("reset");

    // Streaming with 1-cycle memory: latency, throughput and PC wrap.
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    set_knobs(0, 0, 0, 1);
    c0 = consumed;
    repeat (9) cycle();
    chk("first_latency", 32'(first_dv - first_acc), 32'd2);
    chk("throughput", 32'(consumed - c0), 32'd4);

    // Sustained stall: at most one fill of decode plus one skid entry.
    set_knobs(0, 0, 0, 1);
    repeat (3) cycle();
    set_knobs(100, 0, 0, 1);
    a0 = n_acc;
    repeat (8) cycle();
    chk("skid_backpressure", 32'((n_acc - a0) <= 2), 32'd1);
    set_knobs(0, 0, 0, 1);
    repeat (6) cycle();

    // Randomized mixes of stall, back-pressure, latency and redirects.
    set_knobs(30, 5, 30, 3);
    repeat (800) cycle();
    set_knobs(60, 10, 10, 2);
    repeat (800) cycle();
    set_knobs(10, 20, 50, 4);
    repeat (800) cycle();

    // Asynchronous reset while a request is outstanding.
    set_knobs(0, 0, 0, 3);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (mem_busy) found = 1'b1;
    end
    chk("reach_wait", 32'(found), 32'd1);
    #2 rst = 1'b0;
    #1 reset_checks("async_reset");
    quiet_inputs();
    @(negedge clk);
    reset_checks("reset_held");
    rst = 1'b1;
    model_reset();
    set_knobs(0, 0, 0, 1);
    c0 = consumed;
    repeat (9) cycle();
    chk("post_reset_latency", 32'(first_dv - first_acc), 32'd2);
    chk("post_reset_count", 32'(consumed - c0), 32'd4);

    // Forward progress once all disturbances stop.
    set_knobs(0, 0, 0, 2);
    c0 = consumed;
    repeat (40) cycle();
    chk("liveness", 32'((consumed - c0) >= 10), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
